adc_serial_writer: RTL and testbench



---
 rtl/adc_serial_writer.sv | 221 ++++++++++++++++++++++
 tb/tb_adc_serial_writer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_serial_writer.sv
// rtl/adc_serial_writer.sv - Serial register-write engine for the ADC 3-wire control port
//
// Purpose:
//   Receives level requests from the ADC power/sequencing FSM and writes the
//   matching 32-bit register frames MSB-first over sclk/sdata/select. When the
//   sequence is finished, done is raised and held until every request is low.
//
// Ports:
//   Clock        in   system clock
//   Reset        in   asynchronous, active-high reset
//   init         in   level request: write the 4-word init sequence
//   des_enable   in   level request: write {CFG_ADDR, DES_ON_CFG}
//   des_disable  in   level request: write {CFG_ADDR, INIT_CFG}
//   sclk         out  serial clock, idles low; ADC samples on the rising edge
//   sdata        out  serial data, MSB first
//   select       out  active-low frame select
//   done         out  high from sequence completion until all requests are low
//   busy         out  high in any state other than IDLE and DONE

module adc_serial_writer #(
   parameter int          CLK_DIV    = 4,
   parameter int          GAP_CYC    = 8,
   parameter logic [3:0]  CFG_ADDR   = 4'h1,
   parameter logic [15:0] INIT_CFG   = 16'hB2FF,
   parameter logic [15:0] DES_ON_CFG = INIT_CFG | 16'h0400,
   parameter logic [3:0]  INIT_A1    = 4'h2,
   parameter logic [15:0] INIT_D1    = 16'h007F,
   parameter logic [3:0]  INIT_A2    = 4'h3,
   parameter logic [15:0] INIT_D2    = 16'h807F,
   parameter logic [3:0]  INIT_A3    = 4'hA,
   parameter logic [15:0] INIT_D3    = 16'h007F
) (
   input  logic Clock,
   input  logic Reset,
   input  logic init,
   input  logic des_enable,
   input  logic des_disable,
   output logic sclk,
   output logic sdata,
   output logic select,
   output logic done,
   output logic busy
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

   typedef enum logic [2:0] {
      IDLE, LOAD, SETUP, SHIFT, HOLD, GAP, DONE
   } state_t;

   typedef enum logic [1:0] {
      CMD_INIT, CMD_DES_ON, CMD_DES_OFF
   } cmd_t;

   state_t           state;
   state_t           nextState;
   cmd_t             cmd;
   cmd_t             reqCmd;
   logic [1:0]       wordIdx;
   logic [1:0]       lastIdx;
   logic [5:0]       bitCnt;
   logic [DIV_W-1:0] divCnt;
   logic [GAP_W-1:0] gapCnt;
   logic             phaseHigh;
   logic [31:0]      shiftReg;
   logic             anyReq;
   logic             divLast;
   logic             gapLast;
   logic             lastBit;

   function automatic logic [31:0] frameFor(input cmd_t c, input logic [1:0] idx);
      logic [3:0]  a;
      logic [15:0] d;
      a = CFG_ADDR;
      d = INIT_CFG;
      case (c)
         CMD_DES_ON:  d = DES_ON_CFG;
         CMD_DES_OFF: d = INIT_CFG;
         default: begin
            case (idx)
               2'd1: begin a = INIT_A1; d = INIT_D1; end
               2'd2: begin a = INIT_A2; d = INIT_D2; end
               2'd3: begin a = INIT_A3; d = INIT_D3; end
               default: begin a = CFG_ADDR; d = INIT_CFG; end
            endcase
         end
      endcase
      return {12'h001, a, d};
   endfunction

   assign anyReq  = init | des_enable | des_disable;
   assign reqCmd  = init ? CMD_INIT : (des_disable ? CMD_DES_OFF : CMD_DES_ON);
   assign lastIdx = (cmd == CMD_INIT) ? 2'd3 : 2'd0;
   assign divLast = (divCnt == DIV_LAST);
   assign gapLast = (gapCnt == GAP_LAST);
   assign lastBit = (bitCnt == 6'd31);

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      sclk      = 1'b0;
      sdata     = 1'b0;
      select    = 1'b1;
      done      = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (anyReq) nextState = LOAD;
         end
         LOAD: nextState = SETUP;
         SETUP: begin
            select = 1'b0;
            sdata  = shiftReg[31];
            if (divLast) nextState = SHIFT;
         end
         SHIFT: begin
            select = 1'b0;
            sdata  = shiftReg[31];
            sclk   = phaseHigh;
            if (divLast && phaseHigh && lastBit) nextState = HOLD;
         end
         HOLD: begin
            select = 1'b0;
            sdata  = shiftReg[31];
            if (divLast) nextState = GAP;
         end
         GAP: begin
            if (gapLast) nextState = (wordIdx != lastIdx) ? SETUP : DONE;
         end
         DONE: begin
            busy = 1'b0;
            done = 1'b1;
            if (!anyReq) nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   // Datapath. The command is captured when IDLE accepts a request so later
   // request changes cannot alter a sequence already under way.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         cmd       <= CMD_INIT;
         wordIdx   <= 2'd0;
         bitCnt    <= 6'd0;
         divCnt    <= '0;
         gapCnt    <= '0;
         phaseHigh <= 1'b0;
         shiftReg  <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (anyReq) cmd <= reqCmd;
            end
            LOAD: begin
               wordIdx  <= 2'd0;
               shiftReg <= frameFor(cmd, 2'd0);
               divCnt   <= '0;
            end
            SETUP: begin
               if (divLast) begin
                  divCnt    <= '0;
                  bitCnt    <= 6'd0;
                  phaseHigh <= 1'b0;
               end else begin
                  divCnt <= divCnt + DIV_W'(1);
               end
            end
            SHIFT: begin
               if (divLast) begin
                  divCnt <= '0;
                  if (!phaseHigh) begin
                     phaseHigh <= 1'b1;
                  end else begin
                     phaseHigh <= 1'b0;
                     // Next bit is presented together with the falling sclk edge.
                     if (!lastBit) begin
                        bitCnt   <= bitCnt + 6'd1;
                        shiftReg <= {shiftReg[30:0], 1'b0};
                     end
                  end
               end else begin
                  divCnt <= divCnt + DIV_W'(1);
               end
            end
            HOLD: begin
               if (divLast) begin
                  divCnt <= '0;
                  gapCnt <= '0;
               end else begin
                  divCnt <= divCnt + DIV_W'(1);
               end
            end
            GAP: begin
               if (gapLast) begin
                  gapCnt <= '0;
                  if (wordIdx != lastIdx) begin
                     wordIdx  <= wordIdx + 2'd1;
                     shiftReg <= frameFor(cmd, wordIdx + 2'd1);
                  end
               end else begin
                  gapCnt <= gapCnt + GAP_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_serial_writer.sv
// tb/tb_adc_serial_writer.sv - Scoreboard testbench for adc_serial_writer

module tb_adc_serial_writer;

   localparam int DIV0 = 2;
   localparam int GAP0 = 8;
   localparam int DIV1 = 4;
   localparam int GAP1 = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [1:0] rstV, initR, desOnR, desOffR;
   logic [1:0] sclkV, sdataV, selV, doneV, busyV;

   adc_serial_writer #(.CLK_DIV(DIV0), .GAP_CYC(GAP0)) dut0 (
      .Clock(clk), .Reset(rstV[0]), .init(initR[0]), .des_enable(desOnR[0]),
      .des_disable(desOffR[0]), .sclk(sclkV[0]), .sdata(sdataV[0]),
      .select(selV[0]), .done(doneV[0]), .busy(busyV[0]));

   adc_serial_writer #(.CLK_DIV(DIV1), .GAP_CYC(GAP1)) dut1 (
      .Clock(clk), .Reset(rstV[1]), .init(initR[1]), .des_enable(desOnR[1]),
      .des_disable(desOffR[1]), .sclk(sclkV[1]), .sdata(sdataV[1]),
      .select(selV[1]), .done(doneV[1]), .busy(busyV[1]));

   int nChecks = 0;
   int nFails  = 0;

   logic [31:0] expQ  [2][$];
   int          doneQ [2][$];
   int          dropQ [2][$];

   function automatic int divOf(input int i);
      return (i == 0) ? DIV0 : DIV1;
   endfunction

   function automatic int gapOf(input int i);
      return (i == 0) ? GAP0 : GAP1;
   endfunction

   function automatic logic [31:0] mk(input logic [3:0] a, input logic [15:0] d);
      return {12'h001, a, d};
   endfunction

   task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s dut%0d: got %h expected %h", name, i, act, exp);
      end
   endtask

   task automatic drive(input int i, input logic [2:0] r);
      initR[i]   = r[0];
      desOnR[i]  = r[1];
      desOffR[i] = r[2];
   endtask

   // Reference model: priority init > des_disable > des_enable; frames are
   // {12'h001, addr, data}; latency = 2 + N*(66*div + gap).
   task automatic pushFrames(input int i, input logic [2:0] r, output int n);
      if (r[0]) begin
         expQ[i].push_back(mk(4'h1, 16'hB2FF));
         expQ[i].push_back(mk(4'h2, 16'h007F));
         expQ[i].push_back(mk(4'h3, 16'h807F));
         expQ[i].push_back(mk(4'hA, 16'h007F));
         n = 4;
      end else if (r[2]) begin
         expQ[i].push_back(mk(4'h1, 16'hB2FF));
         n = 1;
      end else begin
         expQ[i].push_back(mk(4'h1, 16'hB2FF | 16'h0400));
         n = 1;
      end
   endtask

   task automatic waitDoneRelease(input int i, input int holdCyc);
      int t;
      t = 0;
      while (!doneV[i] && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (!doneV[i]) check("done_timeout", i, 32'(doneV[i]), 32'd1);
      for (int k = 0; k < holdCyc; k++) begin
         @(negedge clk);
         drive(i, 3'($urandom_range(1, 7)));
      end
      @(negedge clk);
      drive(i, 3'b000);
      dropQ[i].push_back(cyc + 1);
      repeat (2) @(negedge clk);
   endtask

   task automatic runCmd(input int i, input logic [2:0] r, input int holdCyc);
      int n;
      pushFrames(i, r, n);
      @(negedge clk);
      drive(i, r);
      doneQ[i].push_back(cyc + 2 + n * (66 * divOf(i) + gapOf(i)));
      waitDoneRelease(i, holdCyc);
   endtask

   // Monitor: reconstructs frames from the pins and checks them against the
   // expected queues, plus framing and bit timing.
   logic        pSel [2], pSclk [2], pSdata [2], pDone [2];
   bit          inSeq [2], firstRun [2];
   int          winCnt [2], rises [2], runLen [2], gapCnt [2], tErr [2];
   logic [31:0] word [2];

   initial begin
      int d;
      int e;
      logic [31:0] w;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (rstV[i]) begin
               pSel[i] = 1'b1; pSclk[i] = 1'b0; pSdata[i] = 1'b0; pDone[i] = 1'b0;
               inSeq[i] = 1'b0; gapCnt[i] = 0;
            end else begin
               d = divOf(i);
               if (!selV[i]) begin
                  if (pSel[i]) begin
                     if (inSeq[i]) check("gap_cycles", i, 32'(gapCnt[i]), 32'(gapOf(i)));
                     winCnt[i] = 0; rises[i] = 0; word[i] = 32'd0;
                     runLen[i] = 0; firstRun[i] = 1'b1; tErr[i] = 0;
                  end
                  winCnt[i]++;
                  if (sclkV[i] && sdataV[i] !== pSdata[i]) tErr[i]++;
                  if (sclkV[i] && !pSclk[i]) begin
                     rises[i]++;
                     word[i] = {word[i][30:0], sdataV[i]};
                     if (runLen[i] != (firstRun[i] ? 2 * d : d)) tErr[i]++;
                     firstRun[i] = 1'b0;
                     runLen[i] = 0;
                  end else if (!sclkV[i] && pSclk[i]) begin
                     if (runLen[i] != d) tErr[i]++;
                     runLen[i] = 0;
                  end
                  runLen[i]++;
               end else if (!pSel[i]) begin
                  if (runLen[i] != d || pSclk[i]) tErr[i]++;
                  w = (expQ[i].size() > 0) ? expQ[i].pop_front() : 32'hxxxxxxxx;
                  check("frame_word", i, word[i], w);
                  check("sclk_rises", i, 32'(rises[i]), 32'd32);
                  check("select_window", i, 32'(winCnt[i]), 32'(66 * d));
                  check("bit_timing_errors", i, 32'(tErr[i]), 32'd0);
                  inSeq[i] = 1'b1;
                  gapCnt[i] = 1;
               end else begin
                  gapCnt[i]++;
               end
               if (!busyV[i]) inSeq[i] = 1'b0;
               if (doneV[i] && !pDone[i]) begin
                  e = (doneQ[i].size() > 0) ? doneQ[i].pop_front() : -1;
                  check("done_rise_cycle", i, 32'(cyc), 32'(e));
               end else if (!doneV[i] && pDone[i]) begin
                  e = (dropQ[i].size() > 0) ? dropQ[i].pop_front() : -1;
                  check("done_fall_cycle", i, 32'(cyc), 32'(e));
               end
               pSel[i] = selV[i]; pSclk[i] = sclkV[i]; pSdata[i] = sdataV[i]; pDone[i] = doneV[i];
            end
         end
      end
   end

   initial begin
      int bad [2];
      int n, t, frames, rcnt;
      logic ps, pc;
      rstV = 2'b11; initR = 2'b00; desOnR = 2'b00; desOffR = 2'b00;
      repeat (3) @(negedge clk);
      rstV = 2'b00;

      bad[0] = 0; bad[1] = 0;
      repeat (100) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++)
            if (sclkV[i] !== 1'b0 || selV[i] !== 1'b1 || doneV[i] !== 1'b0 || busyV[i] !== 1'b0) bad[i]++;
      end
      check("idle_outputs", 0, 32'(bad[0]), 32'd0);
      check("idle_outputs", 1, 32'(bad[1]), 32'd0);

      runCmd(0, 3'b010, 5);
      runCmd(0, 3'b001, 3);
      runCmd(0, 3'b011, 2);
      for (int k = 0; k < 8; k++) begin
         runCmd(0, 3'($urandom_range(1, 7)), $urandom_range(0, 4));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      // Asynchronous reset in the low phase of bit 15 of the second init frame.
      pushFrames(0, 3'b001, n);
      @(negedge clk);
      drive(0, 3'b001);
      doneQ[0].push_back(cyc + 2 + n * (66 * DIV0 + GAP0));
      t = 0; frames = 0; rcnt = 0; ps = 1'b1; pc = 1'b0;
      while (t < 3000 && !(frames == 2 && rcnt == 16 && sclkV[0] == 1'b0)) begin
         @(negedge clk);
         t++;
         if (!selV[0] && ps) begin frames++; rcnt = 0; end
         if (sclkV[0] && !pc) rcnt++;
         ps = selV[0]; pc = sclkV[0];
      end
      if (t >= 3000) check("bit15_timeout", 0, 32'(t), 32'd0);
      #2;
      rstV[0] = 1'b1;
      expQ[0].delete(); doneQ[0].delete(); dropQ[0].delete();
      #1;
      check("reset_select", 0, 32'(selV[0]), 32'd1);
      check("reset_sclk", 0, 32'(sclkV[0]), 32'd0);
      check("reset_busy", 0, 32'(busyV[0]), 32'd0);
      check("reset_done", 0, 32'(doneV[0]), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rstV[0] = 1'b0;
      pushFrames(0, 3'b001, n);
      doneQ[0].push_back(cyc + 2 + n * (66 * DIV0 + GAP0));
      waitDoneRelease(0, 2);

      runCmd(1, 3'b100, 2);
      runCmd(1, 3'b001, 1);
      runCmd(1, 3'b010, 0);

      repeat (5) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check("leftover_frames", i, 32'(expQ[i].size()), 32'd0);
         check("leftover_done", i, 32'(doneQ[i].size() + dropQ[i].size()), 32'd0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
